// File: rtl/pipe_pkg.sv
// Shared types and constants for the issue controller in front of the
// 4-stage regbank/ALU/membank pipeline.
package pipe_pkg;

   localparam int REG_N  = 16;
   localparam int MEM_N  = 256;
   localparam int DATA_W = 16;
   localparam int RIDX_W = $clog2(REG_N);
   localparam int ADDR_W = $clog2(MEM_N);
   localparam int FUNC_W = 4;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [FUNC_W-1:0] {
      FUNC_ADD = 4'h0,
      FUNC_SUB = 4'h1,
      FUNC_AND = 4'h2,
      FUNC_OR  = 4'h3,
      FUNC_XOR = 4'h4,
      FUNC_NOP = 4'hF
   } func_e;

   typedef struct packed {
      logic [RIDX_W-1:0] rs1;
      logic [RIDX_W-1:0] rs2;
      logic [RIDX_W-1:0] rd;
      logic [FUNC_W-1:0] func;
      logic [ADDR_W-1:0] addr;
   } instr_t;

endpackage

// File: rtl/issue_fifo.sv
// Instruction FIFO with valid/ready push side and a combinational head peek.
module issue_fifo
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push_valid,
   output logic   push_ready,
   input  instr_t push_data,
   input  logic   pop,
   output logic   head_valid,
   output instr_t head_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count;
   logic        push;
   instr_t      mem_q [DEPTH];

   // Pointers carry one extra bit so full and empty differ without a flag.
   always_comb begin
      count      = wr_ptr_q - rd_ptr_q;
      push_ready = (count != (AW+1)'(DEPTH));
      head_valid = (count != '0);
      push       = push_valid && push_ready;
      wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d   = rd_ptr_q + (AW+1)'(pop && head_valid);
      head_data  = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue scheduler: queues instructions, holds back RAW-dependent ones until
// in-flight destinations are readable, and issues one instruction per cycle.
module pipe_issue_ctrl
   import pipe_pkg::*;
#(
   parameter int         DEPTH    = 4,
   parameter int         HAZ_WIN  = 2,
   parameter logic [3:0] NOP_FUNC = FUNC_NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_rs1,
   input  logic [3:0]  in_rs2,
   input  logic [3:0]  in_rd,
   input  logic [3:0]  in_func,
   input  logic [7:0]  in_addr,
   input  logic        hold,
   output logic        iss_valid,
   output logic [3:0]  iss_rs1,
   output logic [3:0]  iss_rs2,
   output logic [3:0]  iss_rd,
   output logic [3:0]  iss_func,
   output logic [7:0]  iss_addr,
   output logic        stall,
   output logic        busy,
   output logic [15:0] issued_cnt
);

   // Handshake: a push happens on a rising edge where in_valid && in_ready;
   // in_ready depends only on FIFO occupancy, never on in_valid.
   instr_t in_instr;
   instr_t head;
   logic   head_valid;
   logic   hazard;
   logic   iss_fire;

   logic [HAZ_WIN-1:0] sb_valid_q, sb_valid_d;
   logic [3:0]         sb_rd_q [HAZ_WIN];
   logic [3:0]         sb_rd_d [HAZ_WIN];

   logic        iss_valid_q, iss_valid_d;
   logic [3:0]  iss_rs1_q, iss_rs1_d;
   logic [3:0]  iss_rs2_q, iss_rs2_d;
   logic [3:0]  iss_rd_q, iss_rd_d;
   logic [3:0]  iss_func_q, iss_func_d;
   logic [7:0]  iss_addr_q, iss_addr_d;
   logic [15:0] issued_cnt_q, issued_cnt_d;

   assign in_instr = {in_rs1, in_rs2, in_rd, in_func, in_addr};

   issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_data  (in_instr),
      .pop        (iss_fire),
      .head_valid (head_valid),
      .head_data  (head)
   );

   // Both sources are compared for every func code; a writeback landing this
   // same cycle still counts, since regbank is not readable until next cycle.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_WIN; i++) begin
         if (sb_valid_q[i] && (head.rs1 == sb_rd_q[i] || head.rs2 == sb_rd_q[i]))
            hazard = 1'b1;
      end
      hazard   = hazard && head_valid;
      iss_fire = head_valid && !hazard && !hold;
      stall    = head_valid && hazard && !hold;
      busy     = head_valid || (|sb_valid_q);

      sb_valid_d    = sb_valid_q;
      sb_rd_d       = sb_rd_q;
      sb_valid_d[0] = iss_fire;
      sb_rd_d[0]    = head.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
         sb_valid_d[i] = sb_valid_q[i-1];
         sb_rd_d[i]    = sb_rd_q[i-1];
      end

      iss_valid_d  = iss_fire;
      iss_rs1_d    = iss_fire ? head.rs1  : iss_rs1_q;
      iss_rs2_d    = iss_fire ? head.rs2  : iss_rs2_q;
      iss_rd_d     = iss_fire ? head.rd   : iss_rd_q;
      iss_addr_d   = iss_fire ? head.addr : iss_addr_q;
      iss_func_d   = iss_fire ? head.func : NOP_FUNC;
      issued_cnt_d = issued_cnt_q + 16'(iss_fire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_valid_q   <= '0;
         for (int i = 0; i < HAZ_WIN; i++) sb_rd_q[i] <= '0;
         iss_valid_q  <= 1'b0;
         iss_rs1_q    <= '0;
         iss_rs2_q    <= '0;
         iss_rd_q     <= '0;
         iss_func_q   <= NOP_FUNC;
         iss_addr_q   <= '0;
         issued_cnt_q <= '0;
      end else begin
         sb_valid_q   <= sb_valid_d;
         sb_rd_q      <= sb_rd_d;
         iss_valid_q  <= iss_valid_d;
         iss_rs1_q    <= iss_rs1_d;
         iss_rs2_q    <= iss_rs2_d;
         iss_rd_q     <= iss_rd_d;
         iss_func_q   <= iss_func_d;
         iss_addr_q   <= iss_addr_d;
         issued_cnt_q <= issued_cnt_d;
      end
   end

   assign iss_valid  = iss_valid_q;
   assign iss_rs1    = iss_rs1_q;
   assign iss_rs2    = iss_rs2_q;
   assign iss_rd     = iss_rd_q;
   assign iss_func   = iss_func_q;
   assign iss_addr   = iss_addr_q;
   assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: issued instructions are checked
// in order against a queue filled as the producer side is driven.
module tb_pipe_issue_ctrl;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic        in_valid = 1'b0;
   logic        hold     = 1'b0;
   logic [3:0]  in_rs1   = '0;
   logic [3:0]  in_rs2   = '0;
   logic [3:0]  in_rd    = '0;
   logic [3:0]  in_func  = '0;
   logic [7:0]  in_addr  = '0;
   logic        in_ready;
   logic        iss_valid;
   logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
   logic [7:0]  iss_addr;
   logic        stall;
   logic        busy;
   logic [15:0] issued_cnt;

   int n_checks     = 0;
   int n_fail       = 0;
   int cyc          = 0;
   int stall_cycles = 0;
   int exp_cnt      = 0;

   logic [23:0] exp_q[$];
   int          iss_cyc_q[$];

   always #5 clk = ~clk;

   pipe_issue_ctrl #(.DEPTH(4), .HAZ_WIN(2), .NOP_FUNC(4'hF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_rd      (in_rd),
      .in_func    (in_func),
      .in_addr    (in_addr),
      .hold       (hold),
      .iss_valid  (iss_valid),
      .iss_rs1    (iss_rs1),
      .iss_rs2    (iss_rs2),
      .iss_rd     (iss_rd),
      .iss_func   (iss_func),
      .iss_addr   (iss_addr),
      .stall      (stall),
      .busy       (busy),
      .issued_cnt (issued_cnt)
   );

   // Output monitor: every issued instruction must match the queue head,
   // every bubble must carry the NOP func code.
   always @(posedge clk) begin
      logic [23:0] got;
      logic [23:0] exp;
      #1;
      cyc++;
      if (stall) stall_cycles++;
      if (rst_n) begin
         got = {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr};
         n_checks++;
         if (iss_valid) begin
            iss_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL issue_unexpected got=%h required=none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL issue_fields got=%h required=%h", got, exp);
               end
            end
         end else if (iss_func !== 4'hF) begin
            n_fail++;
            $display("FAIL bubble_func got=%h required=f", iss_func);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_instr(input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic [3:0] rd, input logic [3:0] func,
                             input logic [7:0] addr, input int max_wait);
      bit done = 0;
      int n    = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_rd    = rd;
      in_func  = func;
      in_addr  = addr;
      while (!done) begin
         #1;
         if (in_ready) begin
            exp_q.push_back({rs1, rs2, rd, func, addr});
            exp_cnt++;
            done = 1;
         end
         @(posedge clk);
         if (!done) begin
            n++;
            if (n > max_wait) begin
               n_checks++;
               n_fail++;
               $display("FAIL push_timeout got=in_ready_low required=accept_within_%0d", max_wait);
               done = 1;
            end else begin
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while ((busy || exp_q.size() != 0) && n < max_cyc);
      n_checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain busy=%b pending=%0d required busy=0 pending=0", busy, exp_q.size());
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if (iss_valid !== 1'b0 || stall !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags got v=%b s=%b b=%b required 0 0 0", iss_valid, stall, busy);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready got=%b required=1", in_ready);
      end
      n_checks++;
      if (iss_func !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_func got=%h required=f", iss_func);
      end
      n_checks++;
      if ({iss_rs1, iss_rs2, iss_rd, iss_addr} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_fields got=%h required=0", {iss_rs1, iss_rs2, iss_rd, iss_addr});
      end
      n_checks++;
      if (issued_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt got=%0d required=0", issued_cnt);
      end
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_independent();
      int d1, d2;
      iss_cyc_q.delete();
      stall_cycles = 0;
      push_instr(4'd6, 4'd1, 4'd10, 4'd2, 8'd125, 5);
      push_instr(4'd9, 4'd8, 4'd12, 4'd3, 8'd126, 5);
      push_instr(4'd2, 4'd4, 4'd13, 4'd4, 8'd125, 5);
      wait_idle(30);
      d1 = -1;
      d2 = -1;
      if (iss_cyc_q.size() == 3) begin
         d1 = iss_cyc_q[1] - iss_cyc_q[0];
         d2 = iss_cyc_q[2] - iss_cyc_q[1];
      end
      n_checks++;
      if (d1 != 1 || d2 != 1) begin
         n_fail++;
         $display("FAIL indep_spacing got=%0d,%0d required=1,1", d1, d2);
      end
      n_checks++;
      if (stall_cycles != 0) begin
         n_fail++;
         $display("FAIL indep_stall got=%0d required=0", stall_cycles);
      end
      n_checks++;
      if (issued_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL indep_cnt got=%0d required=%0d", issued_cnt, exp_cnt);
      end
   endtask

   task automatic test_raw();
      int d;
      iss_cyc_q.delete();
      stall_cycles = 0;
      push_instr(4'd1, 4'd2, 4'd5, 4'd0, 8'd20, 5);
      push_instr(4'd5, 4'd3, 4'd6, 4'd1, 8'd21, 5);
      wait_idle(30);
      d = (iss_cyc_q.size() == 2) ? iss_cyc_q[1] - iss_cyc_q[0] : -1;
      n_checks++;
      if (d != 3) begin
         n_fail++;
         $display("FAIL raw_spacing got=%0d required=3", d);
      end
      n_checks++;
      if (stall_cycles != 2) begin
         n_fail++;
         $display("FAIL raw_stall got=%0d required=2", stall_cycles);
      end
   endtask

   task automatic test_older_slot();
      int d1, d2;
      iss_cyc_q.delete();
      stall_cycles = 0;
      push_instr(4'd3, 4'd4, 4'd7, 4'd2, 8'd30, 5);
      push_instr(4'd1, 4'd2, 4'd8, 4'd0, 8'd31, 5);
      push_instr(4'd0, 4'd7, 4'd9, 4'd1, 8'd32, 5);
      wait_idle(30);
      d1 = -1;
      d2 = -1;
      if (iss_cyc_q.size() == 3) begin
         d1 = iss_cyc_q[1] - iss_cyc_q[0];
         d2 = iss_cyc_q[2] - iss_cyc_q[1];
      end
      n_checks++;
      if (d1 != 1 || d2 != 2) begin
         n_fail++;
         $display("FAIL older_spacing got=%0d,%0d required=1,2", d1, d2);
      end
      n_checks++;
      if (stall_cycles != 1) begin
         n_fail++;
         $display("FAIL older_stall got=%0d required=1", stall_cycles);
      end
   endtask

   task automatic test_full();
      iss_cyc_q.delete();
      @(negedge clk);
      hold = 1'b1;
      for (int i = 0; i < 4; i++)
         push_instr(4'(i), 4'd0, 4'(8 + i), 4'd2, 8'(40 + i), 5);
      @(negedge clk);
      in_valid = 1'b1;
      in_rs1   = 4'd1;
      in_rs2   = 4'd2;
      in_rd    = 4'd12;
      in_func  = 4'd3;
      in_addr  = 8'd44;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready got=%b required=0", in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || iss_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL full_hold got rdy=%b v=%b busy=%b required 0 0 1", in_ready, iss_valid, busy);
      end
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL full_stall got=%b required=0", stall);
      end
      @(negedge clk);
      hold = 1'b0;
      push_instr(4'd1, 4'd2, 4'd12, 4'd3, 8'd44, 10);
      wait_idle(40);
      n_checks++;
      if (iss_cyc_q.size() != 5) begin
         n_fail++;
         $display("FAIL full_count got=%0d required=5", iss_cyc_q.size());
      end
      n_checks++;
      if (issued_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL full_cnt got=%0d required=%0d", issued_cnt, exp_cnt);
      end
   endtask

   task automatic test_hold_hazard();
      int n = 0;
      int d;
      iss_cyc_q.delete();
      push_instr(4'd2, 4'd3, 4'd11, 4'd1, 8'd60, 5);
      push_instr(4'd11, 4'd0, 4'd12, 4'd2, 8'd61, 5);
      #1;
      while (!iss_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      hold     = 1'b1;
      repeat (3) @(negedge clk);
      hold = 1'b0;
      wait_idle(30);
      d = (iss_cyc_q.size() == 2) ? iss_cyc_q[1] - iss_cyc_q[0] : -1;
      n_checks++;
      if (d != 4) begin
         n_fail++;
         $display("FAIL hold_hazard_spacing got=%0d required=4", d);
      end
   endtask

   task automatic test_reset_mid();
      iss_cyc_q.delete();
      @(negedge clk);
      hold = 1'b1;
      push_instr(4'd1, 4'd2, 4'd3, 4'd0, 8'd70, 5);
      push_instr(4'd4, 4'd5, 4'd6, 4'd1, 8'd71, 5);
      push_instr(4'd7, 4'd8, 4'd9, 4'd2, 8'd72, 5);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      #1;
      n_checks++;
      if (iss_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_flags got v=%b rdy=%b busy=%b required 0 1 0", iss_valid, in_ready, busy);
      end
      n_checks++;
      if (issued_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL midreset_cnt got=%0d required=0", issued_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      hold  = 1'b0;
      push_instr(4'd14, 4'd15, 4'd1, 4'd4, 8'd200, 5);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      n_checks++;
      if (iss_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency got iss_valid=%b required=1", iss_valid);
      end
      wait_idle(30);
      n_checks++;
      if (issued_cnt !== 16'd1 || iss_cyc_q.size() != 1) begin
         n_fail++;
         $display("FAIL midreset_after got cnt=%0d n=%0d required 1 1", issued_cnt, iss_cyc_q.size());
      end
   endtask

   task automatic test_random_stream();
      logic [3:0] r1, r2, rd;
      for (int i = 0; i < 20; i++) begin
         r1 = 4'($urandom_range(0, 15));
         r2 = 4'($urandom_range(0, 15));
         rd = 4'($urandom_range(0, 15));
         push_instr(r1, r2, rd, 4'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 10);
      end
      wait_idle(100);
      n_checks++;
      if (issued_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL random_cnt got=%0d required=%0d", issued_cnt, exp_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_independent();
      test_raw();
      test_older_slot();
      test_full();
      test_hold_hazard();
      test_reset_mid();
      test_random_stream();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
